// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: request/status bundle between the decoder (master) and the
// program-counter sequencer (slave).
interface pc_ctrl_if #(
  parameter int PC_W        = 16,
  parameter int OFF_W       = 9,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               stall;
  logic               jump_flag;
  logic               jump_rel;
  logic [PC_W-1:0]    next;
  logic [OFF_W-1:0]   offset;
  logic               call;
  logic               ret;
  logic [PC_W-1:0]    PC_counter;
  logic               halted;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_ovf;
  logic               stack_unf;

  modport master (
    output stall, jump_flag, jump_rel, next, offset, call, ret,
    input  PC_counter, halted, stack_depth, stack_ovf, stack_unf
  );

  modport slave (
    input  stall, jump_flag, jump_rel, next, offset, call, ret,
    output PC_counter, halted, stack_depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter sequencer with saturating end address, absolute or
// PC-relative jumps, a LIFO call/return stack and sticky stack-error flags.
// Priority each edge: reset > stall > ret > call > jump_flag > sequential.
module pc_ctrl #(
  parameter int PC_W        = 16,
  parameter int LAST_ADDR   = 27,
  parameter int RESET_ADDR  = 0,
  parameter int OFF_W       = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       pc_reset_n,
  pc_ctrl_if.slave   bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [PC_W-1:0]    LAST_C  = PC_W'(LAST_ADDR);
  localparam logic [PC_W-1:0]    RESET_C = PC_W'(RESET_ADDR);
  localparam logic [DEPTH_W-1:0] FULL_C  = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_C   = DEPTH_W'(1);

  // Sign-extend the relative offset to PC width.
  function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    logic [PC_W-1:0] ext;
    ext            = {PC_W{off[OFF_W-1]}};
    ext[OFF_W-1:0] = off;
    return ext;
  endfunction

  // Any address beyond the last instruction saturates to it; negative
  // relative results have wrapped high and land here too.
  function automatic logic [PC_W-1:0] clamp_addr(input logic [PC_W-1:0] addr);
    return (addr > LAST_C) ? LAST_C : addr;
  endfunction

  logic [PC_W-1:0]    pc_r;
  logic [DEPTH_W-1:0] depth_r;
  logic               ovf_r;
  logic               unf_r;
  logic [PC_W-1:0]    stack_r [STACK_DEPTH];

  logic [PC_W-1:0]    seq_s;
  logic [PC_W-1:0]    raw_target_s;
  logic [PC_W-1:0]    target_s;
  logic [PC_W-1:0]    pc_n_s;
  logic [DEPTH_W-1:0] depth_n_s;
  logic               ovf_n_s;
  logic               unf_n_s;
  logic               push_s;
  logic [IDX_W-1:0]   push_idx_s;
  logic [IDX_W-1:0]   pop_idx_s;

  // Sequential step, jump target and stack indices from the current state.
  always_comb begin
    seq_s = (pc_r < LAST_C) ? (pc_r + PC_W'(1)) : LAST_C;
    if (bus.jump_rel) begin
      raw_target_s = pc_r + sext_off(bus.offset);
    end else begin
      raw_target_s = bus.next;
    end
    target_s   = clamp_addr(raw_target_s);
    push_idx_s = IDX_W'(depth_r);
    pop_idx_s  = IDX_W'(depth_r - ONE_C);
  end

  // Next-state selection in priority order; the return address pushed by a
  // call is the sequential step, which already saturates at the last address.
  always_comb begin
    pc_n_s    = pc_r;
    depth_n_s = depth_r;
    ovf_n_s   = ovf_r;
    unf_n_s   = unf_r;
    push_s    = 1'b0;
    if (bus.stall) begin
      pc_n_s = pc_r;
    end else if (bus.ret) begin
      if (depth_r != {DEPTH_W{1'b0}}) begin
        pc_n_s    = stack_r[pop_idx_s];
        depth_n_s = depth_r - ONE_C;
      end else begin
        pc_n_s  = seq_s;
        unf_n_s = 1'b1;
      end
    end else if (bus.call) begin
      pc_n_s = target_s;
      if (depth_r < FULL_C) begin
        push_s    = 1'b1;
        depth_n_s = depth_r + ONE_C;
      end else begin
        ovf_n_s = 1'b1;
      end
    end else if (bus.jump_flag) begin
      pc_n_s = target_s;
    end else begin
      pc_n_s = seq_s;
    end
  end

  // Control state register: PC, stack depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (!pc_reset_n) begin
      pc_r    <= RESET_C;
      depth_r <= {DEPTH_W{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_n_s;
      depth_r <= depth_n_s;
      ovf_r   <= ovf_n_s;
      unf_r   <= unf_n_s;
    end
  end

  // Return-address storage; contents need no reset since depth gates reads.
  always_ff @(posedge clk) begin
    if (pc_reset_n && push_s) begin
      stack_r[push_idx_s] <= seq_s;
    end
  end

  assign bus.PC_counter  = pc_r;
  assign bus.halted      = (pc_r == LAST_C);
  assign bus.stack_depth = depth_r;
  assign bus.stack_ovf   = ovf_r;
  assign bus.stack_unf   = unf_r;

endmodule
